demod_seq_ctrl: RTL

DEMOD_SEQ_CTRL -- requirements
Module: demod_seq_ctrl

---
 rtl/demod_seq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/demod_seq_ctrl.sv
// Demodulator sequencer: paces samples into the filter, scales the result into a 14-bit DAC code.
// Define DAC_OFFSET_BIN_EN for an offset-binary data_o; two's complement otherwise.
module demod_seq_ctrl #(
  parameter int DIV_N = 50,
  parameter int TMO_N = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] rect_in,
  input  logic [31:0] filt_out,
  input  logic        filt_done,
  input  logic [1:0]  shift_sel,
  input  logic        clr,
  output logic        filt_ce,
  output logic [11:0] filt_in,
  output logic [13:0] data_o,
  output logic        dac_upd,
  output logic        overrun,
  output logic        sat
);

  localparam int CNT_W = $clog2(DIV_N);
  localparam int TMO_W = (TMO_N > 2) ? $clog2(TMO_N) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_N - 1);
  // BUSY starts one clock after filt_ce, so expiring at TMO_N-2 lands TMO_N clocks after filt_ce
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_N - 2);
`ifdef DAC_OFFSET_BIN_EN
  localparam logic [13:0] DATA_RST = 14'h2000;
`else
  localparam logic [13:0] DATA_RST = 14'h0000;
`endif

  typedef enum logic [2:0] {IDLE, WAIT, CAPT, FIRE, BUSY, OUT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [16:0]      acc_q;
  logic             tick;
  logic             tmo_expire;
  logic             ovr_set;
  logic             sat_set;
  logic             slice_ovf;
  logic [13:0]      slice;
  logic [13:0]      scaled;
  logic [13:0]      dac_code;
  logic             unused_low_bits;

  // Only filt_out[31:15] can reach any output slice
  assign unused_low_bits = &{1'b0, filt_out[14:0]};

  assign tick    = en && (state != IDLE) && (div_cnt == DIV_LAST);
  assign filt_ce = en && (state == FIRE);
  assign dac_upd = en && (state == OUT);
  assign ovr_set = (tick && (state != WAIT)) || tmo_expire;
  assign sat_set = en && (state == OUT) && slice_ovf;

  always_comb begin
    state_nxt  = state;
    tmo_expire = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = WAIT;
        WAIT: if (tick) state_nxt = CAPT;
        CAPT: state_nxt = FIRE;
        FIRE: state_nxt = BUSY;
        BUSY: begin
          if (filt_done) begin
            state_nxt = OUT;
          end else if (tmo_cnt == TMO_LAST) begin
            state_nxt  = WAIT;
            tmo_expire = 1'b1;
          end
        end
        OUT:     state_nxt = WAIT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // acc_q[k] holds filt_out[k+15]; overflow means discarded upper bits disagree with the slice sign
  always_comb begin
    slice     = acc_q[15:2];
    slice_ovf = 1'b0;
    case (shift_sel)
      2'd0: begin
        slice     = acc_q[15:2];
        slice_ovf = acc_q[16] != acc_q[15];
      end
      2'd1: begin
        slice     = acc_q[14:1];
        slice_ovf = acc_q[16:14] != {3{acc_q[14]}};
      end
      2'd2: begin
        slice     = acc_q[13:0];
        slice_ovf = acc_q[16:13] != {4{acc_q[13]}};
      end
      default: begin
        slice     = acc_q[16:3];
        slice_ovf = 1'b0;
      end
    endcase
    scaled = slice_ovf ? (acc_q[16] ? 14'h2000 : 14'h1FFF) : slice;
`ifdef DAC_OFFSET_BIN_EN
    dac_code = {~scaled[13], scaled[12:0]};
`else
    dac_code = scaled;
`endif
  end

  // data_o takes the new code on the edge that closes the dac_upd pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      tmo_cnt <= '0;
      acc_q   <= '0;
      filt_in <= '0;
      data_o  <= DATA_RST;
      overrun <= 1'b0;
      sat     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!en || (state == IDLE) || (div_cnt == DIV_LAST)) div_cnt <= '0;
      else div_cnt <= div_cnt + CNT_W'(1);
      if (state == BUSY) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else tmo_cnt <= '0;
      if (en && (state == CAPT)) filt_in <= rect_in;
      if (en && (state == BUSY) && filt_done) acc_q <= filt_out[31:15];
      if (en && (state == OUT)) data_o <= dac_code;
      overrun <= ovr_set || (overrun && !clr);
      sat     <= sat_set || (sat && !clr);
    end
  end

endmodule
